viterbi_decoder: RTL and testbench

//   Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7,5 octal).

---
 rtl/viterbi_decoder_pkg.sv | 25 ++
 rtl/viterbi_decoder_acs.sv | 44 ++++
 rtl/viterbi_decoder.sv | 180 ++++++++++++++++++
 tb/tb_viterbi_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_decoder_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5 octal) hard-decision Viterbi decoder:
// code constants, the expected-symbol function and the Hamming branch metric.
package viterbi_decoder_pkg;

    localparam int         K        = 3;
    localparam int         N_STATES = 1 << (K - 1);
    localparam logic [2:0] G0       = 3'b111;
    localparam logic [2:0] G1       = 3'b101;

    // Expected {c0,c1} for encoder state {s1,s0} and input bit u.
    // The tap vector is {u,s1,s0}, so G0 covers all three and G1 covers u and s0.
    function automatic logic [1:0] exp_code(input logic [1:0] state, input logic u);
        logic [2:0] taps;
        taps     = {u, state};
        exp_code = {^(taps & G0), ^(taps & G1)};
    endfunction

    // Hamming distance (0..2) between a received pair and an expected pair.
    function automatic logic [1:0] branch_metric(input logic [1:0] code, input logic [1:0] expc);
        logic [1:0] diff;
        diff          = code ^ expc;
        branch_metric = {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select for one next state NS of the K=3 trellis.
// Predecessors are {NS[0],0} and {NS[0],1}; the input bit leading into NS is NS[1].
// Sums saturate at the all-ones metric; ties go to the predecessor with s0=0.
module conv_acs_unit
    import viterbi_decoder_pkg::*;
#(
    parameter int         METRIC_W = 6,
    parameter logic [1:0] NS       = 2'd0
)(
    input  logic [1:0]          code_sig,
    input  logic [METRIC_W-1:0] metric_p0,
    input  logic [METRIC_W-1:0] metric_p1,
    output logic [METRIC_W-1:0] metric_new,
    output logic                decision,
    output logic                u_bit
);

    localparam int         SUM_W = METRIC_W + 1;
    localparam logic       U_IN  = NS[1];
    localparam logic [1:0] PRED0 = {NS[0], 1'b0};
    localparam logic [1:0] PRED1 = {NS[0], 1'b1};

    logic [SUM_W-1:0]    sum0;
    logic [SUM_W-1:0]    sum1;
    logic [METRIC_W-1:0] sat0;
    logic [METRIC_W-1:0] sat1;

    // Candidate metrics through each predecessor, clamped at the metric maximum.
    always_comb begin
        sum0 = {1'b0, metric_p0} + SUM_W'(branch_metric(code_sig, exp_code(PRED0, U_IN)));
        sum1 = {1'b0, metric_p1} + SUM_W'(branch_metric(code_sig, exp_code(PRED1, U_IN)));
        sat0 = sum0[METRIC_W] ? {METRIC_W{1'b1}} : sum0[METRIC_W-1:0];
        sat1 = sum1[METRIC_W] ? {METRIC_W{1'b1}} : sum1[METRIC_W-1:0];
    end

    // Select the smaller candidate; equal metrics keep the s0=0 predecessor.
    always_comb begin
        decision   = (sat1 < sat0);
        metric_new = decision ? sat1 : sat0;
    end

    assign u_bit = U_IN;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, generators 7/5 octal, register-exchange survivors.
// One 2-bit symbol accepted per cycle with in_valid; the bit for symbol k is emitted the cycle
// after symbol k+DEPTH-1 is accepted. start_sig with in_valid restarts metrics, survivors and fill.
// Optional feature: define VITERBI_ERRCNT_EN to add the err_cnt port, which counts accepted
// symbols whose best pre-normalisation metric is non-zero (saturating at 16'hFFFF).
module viterbi_decoder
    import viterbi_decoder_pkg::*;
#(
    parameter int DEPTH    = 15,
    parameter int METRIC_W = 6
)(
    input  logic        clk_sig,
    input  logic        reset_sig,
    input  logic        start_sig,
    input  logic        in_valid,
    input  logic [1:0]  code_sig,
    output logic        out_valid,
    output logic        data_sig
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int                  FILL_W     = $clog2(DEPTH + 1);
    localparam logic [METRIC_W-1:0] METRIC_MAX = {METRIC_W{1'b1}};
    localparam logic [FILL_W-1:0]   FILL_FULL  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0]   FILL_OUT   = FILL_W'(DEPTH - 1);

    // The oldest survivor bit is consumed by the output register in the cycle it is
    // formed, so only DEPTH-1 bits per state need to be stored.
    logic [METRIC_W-1:0] metric_q    [N_STATES];
    logic [METRIC_W-1:0] metric_d    [N_STATES];
    logic [DEPTH-2:0]    surv_q      [N_STATES];
    logic [DEPTH-2:0]    surv_d      [N_STATES];
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic                data_q;
    logic                data_d;

    logic                frame_restart;
    logic [METRIC_W-1:0] prev_metric [N_STATES];
    logic [DEPTH-2:0]    prev_surv   [N_STATES];
    logic [FILL_W-1:0]   prev_fill;
    logic [METRIC_W-1:0] acs_metric  [N_STATES];
    logic [N_STATES-1:0] acs_dec;
    logic [N_STATES-1:0] acs_u;
    logic [METRIC_W-1:0] min_metric;
    logic [METRIC_W-1:0] norm_metric [N_STATES];
    logic [DEPTH-1:0]    full_surv   [N_STATES];
    logic [1:0]          best;
    logic [1:0]          pred_idx;

    // A starting symbol is processed from the reset trellis state instead of the stored one.
    always_comb begin
        frame_restart = in_valid & start_sig;
        for (int i = 0; i < N_STATES; i++) begin
            prev_metric[i] = frame_restart ? ((i == 0) ? '0 : METRIC_MAX) : metric_q[i];
            prev_surv[i]   = frame_restart ? '0 : surv_q[i];
        end
        prev_fill = frame_restart ? '0 : fill_q;
    end

    genvar g;
    generate
        for (g = 0; g < N_STATES; g++) begin : g_acs
            conv_acs_unit #(
                .METRIC_W (METRIC_W),
                .NS       (2'(g))
            ) u_acs (
                .code_sig   (code_sig),
                .metric_p0  (prev_metric[(g % 2) * 2]),
                .metric_p1  (prev_metric[(g % 2) * 2 + 1]),
                .metric_new (acs_metric[g]),
                .decision   (acs_dec[g]),
                .u_bit      (acs_u[g])
            );
        end
    endgenerate

    // Normalise so the best state sits at 0; best is the lowest index holding 0.
    always_comb begin
        min_metric = acs_metric[0];
        for (int i = 1; i < N_STATES; i++) begin
            if (acs_metric[i] < min_metric) begin
                min_metric = acs_metric[i];
            end
        end
        for (int i = 0; i < N_STATES; i++) begin
            norm_metric[i] = acs_metric[i] - min_metric;
        end
        best = 2'd0;
        for (int i = N_STATES - 1; i >= 0; i--) begin
            if (norm_metric[i] == '0) begin
                best = 2'(i);
            end
        end
    end

    // Register exchange: each state inherits its chosen predecessor's path plus its own input bit.
    always_comb begin
        pred_idx = '0;
        for (int i = 0; i < N_STATES; i++) begin
            pred_idx     = {1'(i % 2), acs_dec[i]};
            full_surv[i] = {prev_surv[pred_idx], acs_u[i]};
        end
    end

    // Next-state: update on accepted symbols, hold everything else; out_valid is a one-cycle strobe.
    always_comb begin
        metric_d    = metric_q;
        surv_d      = surv_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        data_d      = data_q;
        if (in_valid) begin
            for (int i = 0; i < N_STATES; i++) begin
                metric_d[i] = norm_metric[i];
                surv_d[i]   = full_surv[i][DEPTH-2:0];
            end
            fill_d      = (prev_fill == FILL_FULL) ? FILL_FULL : prev_fill + 1'b1;
            out_valid_d = (prev_fill >= FILL_OUT);
            data_d      = full_surv[best][DEPTH-1];
        end
    end

    // Trellis state and output registers, asynchronously reset to the start-of-frame state.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            for (int i = 0; i < N_STATES; i++) begin
                metric_q[i] <= (i == 0) ? '0 : METRIC_MAX;
                surv_q[i]   <= '0;
            end
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            data_q      <= 1'b0;
        end else begin
            metric_q    <= metric_d;
            surv_q      <= surv_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_sig  = data_q;

`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;
    logic [15:0] err_base;

    // Count symbols where even the best path needed a correction; restart clears the count.
    always_comb begin
        err_base  = frame_restart ? '0 : err_cnt_q;
        err_cnt_d = err_cnt_q;
        if (in_valid) begin
            err_cnt_d = err_base;
            if ((min_metric != '0) && (err_base != 16'hFFFF)) begin
                err_cnt_d = err_base + 16'd1;
            end
        end
    end

    // Error counter register.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: a reference 7/5 encoder drives code symbols,
// the source data bits are queued and compared against each decoded output bit.
module tb_viterbi_decoder;

    localparam int DEPTH    = 15;
    localparam int METRIC_W = 6;

    // ---------------- clock / reset ----------------
    logic       clk_sig   = 1'b0;
    logic       reset_sig = 1'b1;
    logic       start_sig = 1'b0;
    logic       in_valid  = 1'b0;
    logic [1:0] code_sig  = 2'b00;
    logic       out_valid;
    logic       data_sig;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk_sig = ~clk_sig;

    viterbi_decoder #(
        .DEPTH    (DEPTH),
        .METRIC_W (METRIC_W)
    ) dut (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .start_sig (start_sig),
        .in_valid  (in_valid),
        .code_sig  (code_sig),
        .out_valid (out_valid),
        .data_sig  (data_sig)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [0:0] exp_q[$];
    int         n_tests    = 0;
    int         n_fail     = 0;
    int         frame_fill = 0;
    logic       enc_s1     = 1'b0;
    logic       enc_s0     = 1'b0;
    logic       last_exp   = 1'b0;
    logic       have_out   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bits of a frame that never got decoded: the last min(fill, DEPTH-1) pushed.
    task automatic close_frame(input string tag);
        int want;
        want = (frame_fill < DEPTH - 1) ? frame_fill : DEPTH - 1;
        check_val(tag, 32'(exp_q.size()), 32'(want));
        exp_q.delete();
        frame_fill = 0;
        enc_s1     = 1'b0;
        enc_s0     = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_sym(input logic st, input logic u, input logic [1:0] flip);
        logic [1:0] c;
        if (st) begin
            close_frame("leftover");
        end
        c      = {u ^ enc_s1 ^ enc_s0, u ^ enc_s0};
        enc_s0 = enc_s1;
        enc_s1 = u;
        start_sig = st;
        in_valid  = 1'b1;
        code_sig  = c ^ flip;
        exp_q.push_back(u);
        frame_fill++;
        @(posedge clk_sig);
        #1;
        start_sig = 1'b0;
        in_valid  = 1'b0;
        check_val("out_valid", 32'(out_valid), 32'(frame_fill >= DEPTH));
        have_out = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                last_exp = exp_q.pop_front();
                check_val("data", 32'(data_sig), 32'(last_exp));
                have_out = (frame_fill >= DEPTH);
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk_sig);
        #1;
        check_val("gap_out_valid", 32'(out_valid), 32'd0);
        if (have_out) begin
            check_val("gap_data_hold", 32'(data_sig), 32'(last_exp));
        end
    endtask

    task automatic zero_tail();
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_sym(1'b0, 1'b0, 2'b00);
        end
    endtask

    task automatic mid_reset();
        #2;
        reset_sig = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(data_sig), 32'd0);
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b1;
        exp_q.delete();
        frame_fill = 0;
        enc_s1     = 1'b0;
        enc_s0     = 1'b0;
        have_out   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        reset_sig = 1'b0;
        #1;
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_data", 32'(data_sig), 32'd0);
`ifdef VITERBI_ERRCNT_EN
        check_val("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b1;

        // Error-free counter LSBs.
        for (int i = 0; i < 32; i++) begin
            drive_sym(i == 0, 1'(i % 2), 2'b00);
        end
        zero_tail();
`ifdef VITERBI_ERRCNT_EN
        check_val("t2_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // All-zero data.
        for (int i = 0; i < 40; i++) begin
            drive_sym(i == 0, 1'b0, 2'b00);
        end

        // Single flipped bit at symbol 10.
        for (int i = 0; i < 30; i++) begin
            drive_sym(i == 0, 1'($urandom_range(0, 1)), (i == 10) ? 2'b10 : 2'b00);
        end
        zero_tail();
`ifdef VITERBI_ERRCNT_EN
        check_val("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif

        // Adjacent errors at symbols 20 and 21.
        for (int i = 0; i < 35; i++) begin
            drive_sym(i == 0, 1'($urandom_range(0, 1)),
                      (i == 20) ? 2'b01 : ((i == 21) ? 2'b10 : 2'b00));
        end
        zero_tail();
`ifdef VITERBI_ERRCNT_EN
        check_val("t5_err_cnt_range", 32'((err_cnt >= 16'd1) && (err_cnt <= 16'd2)), 32'd1);
`endif

        // Reset mid-stream, then continue without start_sig.
        for (int i = 0; i < 20; i++) begin
            drive_sym(i == 0, 1'($urandom_range(0, 1)), 2'b00);
        end
        mid_reset();
        for (int i = 0; i < 25; i++) begin
            drive_sym(1'b0, 1'($urandom_range(0, 1)), 2'b00);
        end
        zero_tail();

        // Idle gaps every other symbol and a new start mid-stream.
        for (int i = 0; i < 20; i++) begin
            drive_sym(i == 0, 1'($urandom_range(0, 1)), 2'b00);
            if (i % 2 == 1) idle_cycle();
        end
        for (int i = 0; i < 25; i++) begin
            drive_sym(i == 0, 1'($urandom_range(0, 1)), 2'b00);
            if (i % 2 == 1) idle_cycle();
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_sym(1'b0, 1'b0, 2'b00);
            idle_cycle();
        end
        close_frame("final_leftover");

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
